aes_key_schedule: RTL and testbench
===================================

AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 Parameter NUM_ROUNDS, default 10: number of round keys generated after round key 0; only 10 (AES-128) is supported.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to expand key_in; sampled only in IDLE.
REQ-005 key_in  input  [0:127]  cipher key; bit 0 is the MSB of byte 0; sampled with start.
REQ-006 key_ready  input  1  downstream round stage accepts round_key this cycle.
REQ-007 round_key  output  [0:127]  current round key, same bit order as key_in.
REQ-008 round_num  output  4  index (0..10) of round_key.
REQ-009 key_valid  output  1  round_key/round_num are valid.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse after round key 10 is accepted.
REQ-012 rd_addr  input  4  read index into stored round keys (KEY_STORE_EN only).
REQ-013 rd_key  output  [0:127]  stored round key at rd_addr, registered, 1-cycle latency.

Function
REQ-014 The FSM SHALL have the states IDLE, GEN and FINISH.
- IDLE -> GEN on start.
- GEN -> FINISH on an accepted handshake with round_num=10.
- FINISH -> IDLE unconditionally.
REQ-015 On start in IDLE, the block SHALL load key_in into round_key, set round_num=0 and assert key_valid in the next cycle.
REQ-016 A handshake SHALL occur when key_valid and key_ready are both high; round_key SHALL then advance to the next round key in the following cycle (1 round key per cycle at full throughput).
REQ-017 While key_valid=1 and key_ready=0, round_key, round_num and key_valid SHALL hold their values unchanged.
REQ-018 Next key, per FIPS-197 with words w0..w3 (w0 = bits 0:31):
- t = SubWord(RotWord(w3)) xor {Rcon[r],00,00,00};
- w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-019 The Rcon sequence for r=1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-020 round_num SHALL increment by 1 per handshake and SHALL NOT wrap past 10.
REQ-021 In FINISH, the block SHALL drive key_valid=0 and done=1 for exactly one cycle.
REQ-022 A start asserted while busy=1 SHALL be ignored, with no effect on the in-progress expansion.
REQ-023 A start asserted in the same cycle that done=1 SHALL be ignored; a new start is accepted only from IDLE in the following cycle.

Reset
REQ-024 Assertion of reset (low) SHALL immediately force:
- state = IDLE;
- round_key, round_num, rd_key = 0;
- key_valid, busy, done = 0.
REQ-025 Reset asserted mid-expansion SHALL abandon the expansion; no done pulse SHALL be issued.
REQ-026 Stored keys SHALL be cleared to 0 on reset.

Configuration
REQ-027 With macro AES_KEY_STORE_EN defined:
- each round key SHALL be written into an 11-entry store when it is first presented;
- rd_key SHALL return entry rd_addr one cycle later;
- rd_addr values greater than 10 SHALL return 0.
REQ-028 Without AES_KEY_STORE_EN, no store SHALL be built and rd_key SHALL be tied to 0.

Structure
REQ-029 A shared package SHALL hold:
- the state enumeration;
- the Rcon table;
- the constants NUM_ROUNDS=10 and KEY_W=128.
REQ-030 SubWord SHALL use four instances of one combinational byte S-box sub-module, key_sbox; its table SHALL be identical to the S-box used by the encryption round.
REQ-031 All state SHALL be held in one clocked process; next-key logic SHALL be combinational.

Verification
REQ-032 Start with key_in=2b7e151628aed2a6abf7158809cf4f3c and key_ready=1 -> the bench SHALL check:
- round 0 = key_in;
- round 1 = a0fafe1788542cb123a339392a6c7605;
- round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
- done pulses once, 12 cycles after start.
REQ-033 Same key, with key_ready held low for 3 cycles at round 4 -> round_key and round_num hold for 3 cycles, then the sequence completes with correct values.
REQ-034 start pulsed again at round 5 -> ignored; the sequence continues unchanged to round 10.
REQ-035 reset pulsed low at round 7 -> all outputs 0 immediately and no done pulse; a fresh start then produces round 1 correctly.
REQ-036 With AES_KEY_STORE_EN: after expansion, rd_addr=10 -> rd_key = d014f9a8c9ee2589e13f0cc8b6630ca6 next cycle; rd_addr=12 -> rd_key = 0.
REQ-037 All-zero key_in -> round 1 = 62636363626363636263636362636363.

Source files
------------

// File: rtl/aes_key_schedule_pkg.sv
// Shared types and constants for the AES-128 key schedule: FSM states,
// round-constant table and key geometry.
package aes_key_schedule_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Rcon[1..10], first byte is round 1
    localparam logic [0:79] RCON_TBL = 80'h01020408102040801b36;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (r == 4'(i)) v = RCON_TBL[(i-1)*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// Combinational AES forward S-box for one byte; same table the encryption
// round uses for SubBytes.
module key_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    localparam logic [0:2047] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = TBL[{data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128 round-key generator: one round key per accepted handshake.
// Optional round-key store enabled by defining AES_KEY_STORE_EN.
module aes_key_schedule
    import aes_key_schedule_pkg::*;
#(
    parameter int NUM_ROUNDS = aes_key_schedule_pkg::NUM_ROUNDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [0:KEY_W-1] key_in,
    input  logic             key_ready,
    output logic [0:KEY_W-1] round_key,
    output logic [3:0]       round_num,
    output logic             key_valid,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rd_addr,
    output logic [0:KEY_W-1] rd_key
);

    state_t           state, state_nxt;
    logic [0:KEY_W-1] key_nxt;
    logic [0:31]      w0, w1, w2, w3, rot, sw, t;
    logic             hs, last;

    assign w0   = round_key[0:31];
    assign w1   = round_key[32:63];
    assign w2   = round_key[64:95];
    assign w3   = round_key[96:127];
    assign rot  = {w3[8:31], w3[0:7]};
    assign hs   = key_valid & key_ready;
    assign last = (round_num == 4'(NUM_ROUNDS));

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        key_sbox u_sbox (.data(rot[g*8 +: 8]), .sub(sw[g*8 +: 8]));
    end

    assign t = sw ^ {rcon(round_num + 4'd1), 24'h000000};

    always_comb begin
        key_nxt          = '0;
        key_nxt[0:31]    = w0 ^ t;
        key_nxt[32:63]   = w1 ^ key_nxt[0:31];
        key_nxt[64:95]   = w2 ^ key_nxt[32:63];
        key_nxt[96:127]  = w3 ^ key_nxt[64:95];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = GEN;
            GEN:     if (hs && last) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs follow directly from the state, so they clear with reset
    always_comb begin
        key_valid = (state == GEN);
        done      = (state == FINISH);
        busy      = (state != IDLE);
    end

`ifdef AES_KEY_STORE_EN
    logic [0:KEY_W-1] store [0:NUM_ROUNDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_key <= '0;
            round_num <= '0;
            rd_key    <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                round_key <= key_in;
                round_num <= 4'd0;
                store[0]  <= key_in;
            end else if (hs && !last) begin
                round_key                  <= key_nxt;
                round_num                  <= round_num + 4'd1;
                store[round_num + 4'd1]    <= key_nxt;
            end
            rd_key <= (rd_addr <= 4'(NUM_ROUNDS)) ? store[rd_addr] : '0;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^rd_addr;
    assign rd_key    = '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            round_key <= '0;
            round_num <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                round_key <= key_in;
                round_num <= 4'd0;
            end else if (hs && !last) begin
                round_key <= key_nxt;
                round_num <= round_num + 4'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule using the FIPS-197 key expansion vectors.
module tb_aes_key_schedule;

    typedef struct {
        logic [3:0]   num;
        logic [0:127] key;
        bit           chk;
    } exp_t;

    logic         clk, reset, start, key_ready;
    logic [0:127] key_in, round_key, rd_key;
    logic [3:0]   round_num, rd_addr;
    logic         key_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t sb_q[$];
    int   done_q[$];

    logic [0:127] fips [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes_key_schedule dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .key_ready(key_ready), .round_key(round_key), .round_num(round_num),
        .key_valid(key_valid), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_key(rd_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // monitor: hold checks during stalls, pop on handshakes, check done timing
    initial begin
        logic         stall_prev;
        logic [0:127] prev_key;
        logic [3:0]   prev_num;
        exp_t         e;
        int           d;
        stall_prev = 1'b0;
        prev_key   = '0;
        prev_num   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (round_key !== prev_key || round_num !== prev_num || key_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL hold got num=%0d key=%h vld=%b want num=%0d key=%h vld=1",
                                 round_num, round_key, key_valid, prev_num, prev_key);
                    end
                end
                if (key_valid && key_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_key got num=%0d key=%h want none", round_num, round_key);
                    end else begin
                        e = sb_q.pop_front();
                        if (round_num !== e.num || (e.chk && round_key !== e.key)) begin
                            errors++;
                            $display("FAIL round_key got num=%0d key=%h want num=%0d key=%h",
                                     round_num, round_key, e.num, e.key);
                        end
                    end
                end
                stall_prev = key_valid && !key_ready;
                prev_key   = round_key;
                prev_num   = round_num;
                if (done) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected got cycle=%0d want no pulse", cyc);
                    end else begin
                        d = done_q.pop_front();
                        if (cyc != d) begin
                            errors++;
                            $display("FAIL done_time got cycle=%0d want %0d", cyc, d);
                        end
                    end
                end
            end
        end
    end

    task automatic push_fips();
        for (int r = 0; r <= 10; r++) sb_q.push_back('{num: 4'(r), key: fips[r], chk: 1'b1});
    endtask

    task automatic issue(input logic [0:127] k, input int done_delay);
        @(posedge clk); #1;
        key_in = k;
        start  = 1'b1;
        if (done_delay > 0) done_q.push_back(cyc + done_delay);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_round(input int n);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (key_valid && round_num == 4'(n)) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_round got timeout want round %0d", n);
        end
    endtask

    task automatic wait_idle();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(posedge clk); #1;
            if (!busy) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_idle got timeout want busy=0");
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_key"},  round_key, 128'h0);
        check({tag, "_num"},  {124'h0, round_num}, 128'h0);
        check({tag, "_ctl"},  {125'h0, key_valid, busy, done}, 128'h0);
        check({tag, "_rd"},   rd_key, 128'h0);
    endtask

    initial begin
        bit seen;
        reset = 1'b0; start = 1'b0; key_ready = 1'b1; key_in = '0; rd_addr = '0;
        #1;
        check_zero("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // full expansion, full throughput
        push_fips();
        issue(fips[0], 12);
        wait_idle();

        // all-zero key: check round 1 value, remaining rounds by index only
        sb_q.push_back('{num: 4'd0, key: 128'h0, chk: 1'b1});
        sb_q.push_back('{num: 4'd1, key: 128'h62636363626363636263636362636363, chk: 1'b1});
        for (int r = 2; r <= 10; r++) sb_q.push_back('{num: 4'(r), key: 128'h0, chk: 1'b0});
        issue(128'h0, 12);
        wait_idle();

        // stall three cycles at round 4
        push_fips();
        issue(fips[0], 15);
        wait_round(4);
        key_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_num", {124'h0, round_num}, 128'd4);
        check("stall_key", round_key, fips[4]);
        key_ready = 1'b1;
        wait_idle();

        // start pulsed mid-expansion is ignored
        push_fips();
        issue(fips[0], 12);
        wait_round(5);
        key_in = 128'h0;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy_num", {124'h0, round_num}, 128'd6);
        wait_idle();

        // start coincident with done is ignored
        push_fips();
        issue(fips[0], 12);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check("done_seen", {127'h0, seen}, 128'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("done_start_busy", {127'h0, busy}, 128'd0);
        @(posedge clk); #1;
        check("done_start_idle", {126'h0, busy, key_valid}, 128'd0);

`ifdef AES_KEY_STORE_EN
        rd_addr = 4'd10;
        @(posedge clk); #1;
        check("store_rd10", rd_key, fips[10]);
        rd_addr = 4'd12;
        @(posedge clk); #1;
        check("store_rd12", rd_key, 128'h0);
        rd_addr = 4'd1;
        @(posedge clk); #1;
        check("store_rd1", rd_key, fips[1]);
`else
        rd_addr = 4'd10;
        @(posedge clk); #1;
        check("rd_tied", rd_key, 128'h0);
`endif

        // reset mid-expansion at round 7
        push_fips();
        issue(fips[0], 0);
        wait_round(7);
        reset = 1'b0;
        #1;
        check_zero("midreset");
        sb_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
`ifdef AES_KEY_STORE_EN
        rd_addr = 4'd10;
        @(posedge clk); #1;
        check("store_cleared", rd_key, 128'h0);
`endif
        push_fips();
        issue(fips[0], 12);
        wait_idle();

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        check("done_drained", 128'(done_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
